// File: rtl/pc_stack_unit.sv
// pc_stack_unit: program counter with four-way next-PC select and circular return-address stack
module pc_stack_unit #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8,
  parameter logic [WIDTH-1:0] RESET_PC = '0
) (
  input  logic                       Clk,
  input  logic                       Reset,
  input  logic                       LD_PC,
  input  logic [1:0]                 PCMUX,
  input  logic                       PUSH,
  input  logic [WIDTH-1:0]           pc_din1,
  input  logic [WIDTH-1:0]           pc_din2,
  output logic [WIDTH-1:0]           PC,
  output logic [$clog2(DEPTH+1)-1:0] sp_count,
  output logic                       stack_empty,
  output logic                       stack_full,
  output logic                       overflow,
  output logic                       underflow
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0] tp, tp_inc, tp_dec;
  logic [WIDTH-1:0] pc_inc, top, pc_next;
  logic pop, pop_ok, push_ok, swap;
  assign stack_empty = sp_count == '0;
  assign stack_full  = sp_count == CW'(DEPTH);
  assign pc_inc  = PC + WIDTH'(1);
  assign top     = mem[tp];
  assign tp_inc  = (tp == PW'(DEPTH-1)) ? '0 : tp + PW'(1);
  assign tp_dec  = (tp == '0) ? PW'(DEPTH-1) : tp - PW'(1);
  assign pop     = LD_PC && PCMUX == 2'b11;
  assign pop_ok  = pop && !stack_empty;
  assign push_ok = LD_PC && PUSH && !pop;
  assign swap    = pop_ok && PUSH;
  always_comb
    pc_next = (PCMUX == 2'b00) ? pc_inc :
              (PCMUX == 2'b01) ? pc_din1 :
              (PCMUX == 2'b10) ? pc_din2 :
              (stack_empty ? PC : top);
  always_ff @(posedge Clk) begin
    if (Reset) begin
      PC        <= RESET_PC;
      sp_count  <= '0;
      tp        <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else if (LD_PC) begin
      PC <= pc_next;
      if (push_ok) begin
        tp       <= tp_inc;
        sp_count <= stack_full ? sp_count : sp_count + CW'(1);
        overflow <= overflow | stack_full;
      end else if (pop_ok && !swap) begin
        tp       <= tp_dec;
        sp_count <= sp_count - CW'(1);
      end
      if (pop && stack_empty) underflow <= 1'b1;
    end
  end
  // When full, tp_inc lands on the oldest entry, so a push silently discards it
  always_ff @(posedge Clk) begin
    if (!Reset && push_ok) mem[tp_inc] <= pc_inc;
    else if (!Reset && swap) mem[tp] <= pc_inc;
  end
endmodule

// File: tb/tb_pc_stack_unit.sv
// tb_pc_stack_unit: directed vectors with hand-computed expectations for pc_stack_unit
module tb_pc_stack_unit;
  logic        Clk = 0, Reset = 1, LD_PC = 0, PUSH = 0;
  logic [1:0]  PCMUX = 0;
  logic [15:0] pc_din1 = 0, pc_din2 = 0, PC;
  logic [3:0]  sp_count;
  logic        stack_empty, stack_full, overflow, underflow;
  int n_cmp = 0, n_err = 0;

  pc_stack_unit #(.WIDTH(16), .DEPTH(8), .RESET_PC(16'h0000)) dut (
    .Clk(Clk), .Reset(Reset), .LD_PC(LD_PC), .PCMUX(PCMUX), .PUSH(PUSH),
    .pc_din1(pc_din1), .pc_din2(pc_din2), .PC(PC), .sp_count(sp_count),
    .stack_empty(stack_empty), .stack_full(stack_full),
    .overflow(overflow), .underflow(underflow)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic cyc(input logic rst, input logic ld, input logic [1:0] mux, input logic ps,
                     input logic [15:0] d1, input logic [15:0] d2);
    Reset = rst; LD_PC = ld; PCMUX = mux; PUSH = ps; pc_din1 = d1; pc_din2 = d2;
    @(posedge Clk); #1;
  endtask

  initial begin
    cyc(1, 1, 2'b11, 1, 16'h1111, 16'h2222);
    chk("rst_pc", PC, 16'h0000);
    chk("rst_sp", sp_count, 0);
    chk("rst_empty", stack_empty, 1);
    chk("rst_full", stack_full, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_unf", underflow, 0);
    cyc(0, 1, 2'b10, 0, 0, 16'hFFFE);
    chk("ld_din2", PC, 16'hFFFE);
    cyc(0, 1, 2'b00, 0, 0, 0);
    chk("inc_ffff", PC, 16'hFFFF);
    cyc(0, 1, 2'b00, 0, 0, 0);
    chk("inc_wrap", PC, 16'h0000);
    for (int i = 0; i < 3; i++) begin
      cyc(0, 0, 2'b01, 1, 16'h1234, 0);
      chk("hold_pc", PC, 16'h0000);
    end
    chk("hold_sp", sp_count, 0);
    cyc(0, 1, 2'b10, 0, 0, 16'h3000);
    cyc(0, 1, 2'b01, 1, 16'h4000, 0);
    chk("call_pc", PC, 16'h4000);
    chk("call_sp", sp_count, 1);
    chk("call_empty", stack_empty, 0);
    cyc(0, 0, 2'b11, 0, 0, 0);
    chk("hold_pop_pc", PC, 16'h4000);
    chk("hold_pop_sp", sp_count, 1);
    cyc(0, 1, 2'b11, 0, 0, 0);
    chk("ret_pc", PC, 16'h3001);
    chk("ret_sp", sp_count, 0);
    chk("ret_empty", stack_empty, 1);
    for (int i = 1; i <= 9; i++) begin
      cyc(0, 1, 2'b10, 0, 0, 16'(i * 256));
      cyc(0, 1, 2'b01, 1, 16'h0AAA, 0);
      if (i == 8) begin
        chk("full8_sp", sp_count, 8);
        chk("full8_full", stack_full, 1);
        chk("full8_ovf", overflow, 0);
      end
    end
    chk("ovf_sp", sp_count, 8);
    chk("ovf_full", stack_full, 1);
    chk("ovf_flag", overflow, 1);
    chk("ovf_pc", PC, 16'h0AAA);
    for (int k = 0; k < 8; k++) begin
      cyc(0, 1, 2'b11, 0, 0, 0);
      chk("pop_pc", PC, 16'((9 - k) * 256 + 1));
    end
    chk("pop_sp", sp_count, 0);
    chk("pop_unf0", underflow, 0);
    cyc(0, 1, 2'b11, 1, 0, 0);
    chk("unf_flag", underflow, 1);
    chk("unf_pc", PC, 16'h0201);
    chk("unf_sp", sp_count, 0);
    cyc(0, 1, 2'b10, 0, 0, 16'h5000);
    cyc(0, 1, 2'b01, 1, 16'h6000, 0);
    chk("sw_pre_pc", PC, 16'h6000);
    cyc(0, 1, 2'b11, 1, 0, 0);
    chk("swap_pc", PC, 16'h5001);
    chk("swap_sp", sp_count, 1);
    cyc(0, 1, 2'b11, 0, 0, 0);
    chk("swap_top", PC, 16'h6001);
    chk("swap_sp0", sp_count, 0);
    chk("sticky_ovf", overflow, 1);
    cyc(0, 1, 2'b10, 0, 0, 16'h0010);
    for (int i = 0; i < 3; i++) cyc(0, 1, 2'b00, 1, 0, 0);
    chk("mid_pc", PC, 16'h0013);
    chk("mid_sp", sp_count, 3);
    cyc(1, 1, 2'b11, 0, 0, 0);
    chk("mid_rst_pc", PC, 16'h0000);
    chk("mid_rst_sp", sp_count, 0);
    chk("mid_rst_ovf", overflow, 0);
    chk("mid_rst_unf", underflow, 0);
    cyc(0, 1, 2'b11, 0, 0, 0);
    chk("mid_unf", underflow, 1);
    chk("mid_unf_pc", PC, 16'h0000);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
